dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder behind the LSU's DM port. Services single-port word accesses: reads with 1-cycle registered latency, writes under a per-bit active-low write mask.
- Holds the storage array, a one-entry posted write buffer with read merge, and a post-reset zero-initialisation sequencer.
- Sits directly below the LSU; the LSU is the sole initiator.

Parameters:
- DEPTH_LOG2, 14, log2 of word count (16384 x 32-bit words = 64 KB).
- INIT_ZERO, 1, 1 = clear the whole array after reset before accepting accesses; 0 = ready immediately.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- DM_c_en  in  1  chip enable, active-high; 0 = no access this cycle.
- DM_r_en  in  1  1 = read, 0 = write (when DM_c_en=1).
- DM_w_en  in  32  per-bit write mask, active-low (bit=0 writes that bit).
- DM_addr  in  32  byte address; word index = DM_addr[DEPTH_LOG2+1:2]; upper and low 2 bits ignored.
- DM_w_data  in  32  write data, already lane-aligned by the initiator.
- DM_rd_data  out  32  registered read data.
- dm_ready  out  1  1 = accesses accepted (state IDLE).
- wb_valid  out  1  write buffer occupied (debug/verification).

Behaviour:
- Reset (rst=0, async): DM_rd_data=0, wb_valid=0, dm_ready=0, init counter=0, state=INIT if INIT_ZERO else IDLE. Array contents undefined unless INIT runs.
- FSM states: INIT, IDLE.
  - INIT: writes 0 to word[cnt] each cycle, cnt+1.
  - At cnt=DEPTH-1: write that word, then go to IDLE next cycle. dm_ready=1 from the first IDLE cycle.
  - Total INIT = 2^DEPTH_LOG2 cycles.
  - All DM_* inputs are ignored in INIT; DM_rd_data stays 0.
  - Reset mid-INIT restarts from cnt=0.
  - IDLE is terminal until reset.
- Access acceptance, IDLE only:
  - read = c_en & r_en.
  - write = c_en & !r_en & (DM_w_en != 32'hFFFFFFFF).
  - An all-ones mask is a no-op and is not buffered.
- Read latency: a request in cycle t gives DM_rd_data valid in cycle t+1. DM_rd_data holds its value until the next accepted read; it is not cleared on idle or write cycles.
- Write buffer (addr, data, mask), one entry:
  - Write accepted with buffer empty: capture; wb_valid=1 next cycle.
  - Write accepted with buffer full: retire the old entry to the array this cycle (bits where mask=0 take buf data), capture the new one. Same-address back-to-back writes retire in order; no coalescing.
  - Non-read cycle in IDLE (c_en=0, or a no-op write) with buffer full: retire; wb_valid=0 next cycle.
  - Read cycle: the array port is busy; the buffer is held.
- Read merge:
  - At read time, if wb_valid and buffer word index == read word index, register buf data and mask with the match.
  - Cycle t+1: DM_rd_data bit i = (match & !mask[i]) ? buf_data[i] : array_data[i].
  - A write in cycle t+1 must not corrupt the t+1 output; use the registered copy, not the live buffer.
- Array port: exactly one access per cycle (INIT write, read, or retire). Never a read and a retire in the same cycle.
- Address wrap: word index is truncated to DEPTH_LOG2 bits, so aliasing is silent.
- Reset with wb_valid=1 discards the buffered write.
- X on DM_w_data under a masked-off bit must not propagate into the array.

Test Plan:
- Reset + INIT, DEPTH_LOG2=4, INIT_ZERO=1 → dm_ready=0 for 16 cycles then 1; read of addr 0x3C returns 0x00000000 one cycle later.
- Write 0xDEADBEEF to 0x10 with w_en=0, then 3 idle cycles, then read 0x10 → DM_rd_data=0xDEADBEEF at read+1 and held through 2 further idle cycles.
- SB-style write: 0x10 holds 0xDEADBEEF; write data 0x0000AB00 with w_en=0xFFFF00FF to 0x11, then immediate read of 0x10 (buffer still full) → 0xDEADABEF via merge; wb_valid stays 1 during the read, clears after the next idle cycle.
- Back-to-back writes 0x11111111 to 0x20 then 0x22222222 to 0x20 (w_en=0), then read 0x20 → 0x22222222; wb_valid=1 throughout; after one idle cycle the array word 0x20 = 0x22222222.
- Read in cycle t, then write 0x55555555 to the same address at t+1 → DM_rd_data at t+1 shows the pre-write value; a read at t+3 shows 0x55555555.
- During INIT drive a write of 0xFFFFFFFF to 0x0 → ignored; after dm_ready, read 0x0 = 0. Assert rst low mid-INIT at cnt=7 → dm_ready=0 and a full 16 INIT cycles after release.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder sitting below the LSU's DM port.
// Services single-port word accesses with a 1-cycle registered read and
// per-bit active-low masked writes. Writes are posted into a one-entry
// buffer that retires to the array on the next cycle in which the array
// port is free. Reads that hit the buffered word see the buffered bits
// merged over the array data. After reset an optional sequencer clears
// the whole array before accesses are accepted.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous active-low reset
//   DM_c_en     chip enable (1 = access this cycle)
//   DM_r_en     1 = read, 0 = write
//   DM_w_en     per-bit write mask, active-low
//   DM_addr     byte address, word index = DM_addr[DEPTH_LOG2+1:2]
//   DM_w_data   lane-aligned write data
//   DM_rd_data  registered read data, held until the next accepted read
//   dm_ready    1 once the zero-initialisation has finished
//   wb_valid    write buffer occupied
module dm_responder #(
  parameter int DEPTH_LOG2 = 14,
  parameter int INIT_ZERO  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_c_en,
  input  logic        DM_r_en,
  input  logic [31:0] DM_w_en,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_w_data,
  output logic [31:0] DM_rd_data,
  output logic        dm_ready,
  output logic        wb_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [DEPTH_LOG2-1:0] wb_addr_q, wb_addr_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic [31:0]           wb_mask_q, wb_mask_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  merge_hit_q, merge_hit_d;
  logic [31:0]           merge_data_q, merge_data_d;
  logic [31:0]           merge_mask_q, merge_mask_d;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           mem_rdata;
  logic                  mem_we, mem_re;
  logic [DEPTH_LOG2-1:0] mem_waddr, mem_raddr;
  logic [31:0]           mem_wdata, mem_wmask;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  acc_rd, acc_wr;
  logic [31:0]           hit_bits;
  logic                  unused_addr_bits;

  // Upper address bits alias silently onto the array.
  assign req_idx          = DM_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{DM_addr[31:DEPTH_LOG2+2], DM_addr[1:0]};
  assign acc_rd           = DM_c_en & DM_r_en;
  assign acc_wr           = DM_c_en & ~DM_r_en & (DM_w_en != 32'hFFFF_FFFF);

  // Next-state logic. The array port carries exactly one of: an init
  // write, a read, or a buffer retire. Reads win the port and hold the
  // buffer; any other IDLE cycle retires a pending entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wb_valid_d   = wb_valid_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    wb_mask_d    = wb_mask_q;
    rd_valid_d   = rd_valid_q;
    merge_hit_d  = merge_hit_q;
    merge_data_d = merge_data_q;
    merge_mask_d = merge_mask_q;
    mem_we       = 1'b0;
    mem_waddr    = wb_addr_q;
    mem_wdata    = wb_data_q;
    mem_wmask    = wb_mask_q;
    mem_re       = 1'b0;
    mem_raddr    = req_idx;

    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        mem_wmask = '0;
        cnt_d     = cnt_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (acc_rd) begin
          // Snapshot the buffer so a write in the next cycle cannot
          // disturb the merged output.
          mem_re       = 1'b1;
          rd_valid_d   = 1'b1;
          merge_hit_d  = wb_valid_q && (wb_addr_q == req_idx);
          merge_data_d = wb_data_q;
          merge_mask_d = wb_mask_q;
        end else begin
          mem_we = wb_valid_q;
          if (acc_wr) begin
            // Masked-off data bits are forced to 0 so X never leaks.
            wb_valid_d = 1'b1;
            wb_addr_d  = req_idx;
            wb_data_d  = DM_w_data & ~DM_w_en;
            wb_mask_d  = DM_w_en;
          end else begin
            wb_valid_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
      cnt_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      wb_mask_q    <= '1;
      rd_valid_q   <= 1'b0;
      merge_hit_q  <= 1'b0;
      merge_data_q <= '0;
      merge_mask_q <= '1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      wb_mask_q    <= wb_mask_d;
      rd_valid_q   <= rd_valid_d;
      merge_hit_q  <= merge_hit_d;
      merge_data_q <= merge_data_d;
      merge_mask_q <= merge_mask_d;
    end
  end

  // Storage array with bit-granular write enables and a registered read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 32; i++) begin
        if (!mem_wmask[i]) begin
          mem[mem_waddr][i] <= mem_wdata[i];
        end
      end
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_raddr];
    end
  end

  // rd_valid_q gates the raw RAM output so it reads 0 until the first read.
  assign hit_bits   = merge_hit_q ? ~merge_mask_q : 32'h0;
  assign DM_rd_data = rd_valid_q ? ((mem_rdata & ~hit_bits) | (merge_data_q & hit_bits)) : 32'h0;
  assign dm_ready   = (state_q == ST_IDLE);
  assign wb_valid   = wb_valid_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed, table-driven bench for dm_responder with a
// 16-word array and zero-initialisation enabled. Each table row drives one
// cycle of inputs and lists the outputs expected just after that edge.
module tb_dm_responder;

  logic        clk;
  logic        rst;
  logic        DM_c_en;
  logic        DM_r_en;
  logic [31:0] DM_w_en;
  logic [31:0] DM_addr;
  logic [31:0] DM_w_data;
  logic [31:0] DM_rd_data;
  logic        dm_ready;
  logic        wb_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        c_en;
    logic        r_en;
    logic [31:0] w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_wb;
    string       name;
  } vec_t;

  vec_t vecs[$];

  dm_responder #(.DEPTH_LOG2(4), .INIT_ZERO(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .DM_c_en    (DM_c_en),
    .DM_r_en    (DM_r_en),
    .DM_w_en    (DM_w_en),
    .DM_addr    (DM_addr),
    .DM_w_data  (DM_w_data),
    .DM_rd_data (DM_rd_data),
    .dm_ready   (dm_ready),
    .wb_valid   (wb_valid)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void addVec(input logic c, input logic r, input logic [31:0] we,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] erd, input logic ewb, input string nm);
    vec_t v;
    v.c_en = c; v.r_en = r; v.w_en = we; v.addr = a; v.wdata = d;
    v.exp_rd = erd; v.exp_wb = ewb; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic applyStimulus(input logic c, input logic r, input logic [31:0] we,
                               input logic [31:0] a, input logic [31:0] d);
    DM_c_en = c; DM_r_en = r; DM_w_en = we; DM_addr = a; DM_w_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
  endtask

  // Counts cycles until dm_ready rises, driving the given access
  // throughout; checks the INIT length and that rd_data stayed 0.
  task automatic waitReady(input string name, input logic c, input logic r,
                           input logic [31:0] we, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    logic rd_nonzero = 1'b0;
    while (dm_ready !== 1'b1 && n < 64) begin
      applyStimulus(c, r, we, a, d);
      n++;
      if (DM_rd_data !== 32'h0) rd_nonzero = 1'b1;
    end
    checkOutput({name, "_init_cycles"}, 32'(n), 32'd16);
    checkOutput({name, "_rd_zero_in_init"}, {31'h0, rd_nonzero}, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    DM_c_en = 1'b0; DM_r_en = 1'b0; DM_w_en = '1; DM_addr = '0; DM_w_data = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rd_data", DM_rd_data, 32'h0);
    checkOutput("reset_wb_valid", {31'h0, wb_valid}, 32'h0);
    checkOutput("reset_dm_ready", {31'h0, dm_ready}, 32'h0);

    // Abort INIT at cnt=7, then a full INIT with an ignored write driven.
    rst = 1'b1;
    repeat (7) applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    checkOutput("mid_init_not_ready", {31'h0, dm_ready}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("mid_init_reset_ready", {31'h0, dm_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    waitReady("init_w", 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF);

    // Vector table: inputs for one cycle, expected outputs after the edge.
    addVec(1, 1, 32'hFFFFFFFF, 32'h3C, 32'h0,        32'h00000000, 0, "rd_3c_zero");
    addVec(1, 0, 32'h00000000, 32'h10, 32'hDEADBEEF, 32'h00000000, 1, "wr_10");
    addVec(0, 0, 32'hFFFFFFFF, 32'h00, 32'h0,        32'h00000000, 0, "idle1");
    addVec(0, 0, 32'hFFFFFFFF, 32'h00, 32'h0,        32'h00000000, 0, "idle2");
    addVec(0, 0, 32'hFFFFFFFF, 32'h00, 32'h0,        32'h00000000, 0, "idle3");
    addVec(1, 1, 32'hFFFFFFFF, 32'h10, 32'h0,        32'hDEADBEEF, 0, "rd_10");
    addVec(0, 0, 32'hFFFFFFFF, 32'h00, 32'h0,        32'hDEADBEEF, 0, "hold1");
    addVec(0, 0, 32'hFFFFFFFF, 32'h00, 32'h0,        32'hDEADBEEF, 0, "hold2");
    addVec(1, 0, 32'hFFFF00FF, 32'h11, 32'h0000AB00, 32'hDEADBEEF, 1, "sb_wr_11");
    addVec(1, 1, 32'hFFFFFFFF, 32'h10, 32'h0,        32'hDEADABEF, 1, "sb_merge_rd");
    addVec(0, 0, 32'hFFFFFFFF, 32'h00, 32'h0,        32'hDEADABEF, 0, "sb_retire");
    addVec(1, 1, 32'hFFFFFFFF, 32'h00, 32'h0,        32'h00000000, 0, "rd_0_init_ignored");
    addVec(1, 0, 32'h00000000, 32'h20, 32'h11111111, 32'h00000000, 1, "b2b_wr1");
    addVec(1, 0, 32'h00000000, 32'h20, 32'h22222222, 32'h00000000, 1, "b2b_wr2");
    addVec(1, 1, 32'hFFFFFFFF, 32'h20, 32'h0,        32'h22222222, 1, "b2b_merge_rd");
    addVec(0, 0, 32'hFFFFFFFF, 32'h00, 32'h0,        32'h22222222, 0, "b2b_retire");
    addVec(1, 1, 32'hFFFFFFFF, 32'h20, 32'h0,        32'h22222222, 0, "b2b_array_rd");
    addVec(1, 1, 32'hFFFFFFFF, 32'h10, 32'h0,        32'hDEADABEF, 0, "raw_rd_t");
    addVec(1, 0, 32'h00000000, 32'h10, 32'h55555555, 32'hDEADABEF, 1, "raw_wr_t1");
    addVec(0, 0, 32'hFFFFFFFF, 32'h00, 32'h0,        32'hDEADABEF, 0, "raw_idle_t2");
    addVec(1, 1, 32'hFFFFFFFF, 32'h10, 32'h0,        32'h55555555, 0, "raw_rd_t3");
    addVec(1, 0, 32'hFFFFFFFF, 32'h10, 32'h0,        32'h55555555, 0, "noop_wr");
    addVec(1, 1, 32'hFFFFFFFF, 32'h10, 32'h0,        32'h55555555, 0, "noop_rd");
    addVec(1, 0, 32'h00000000, 32'h50, 32'hA5A5A5A5, 32'h55555555, 1, "alias_wr_50");
    addVec(1, 1, 32'hFFFFFFFF, 32'h10, 32'h0,        32'hA5A5A5A5, 1, "alias_merge_rd");
    addVec(0, 0, 32'hFFFFFFFF, 32'h00, 32'h0,        32'hA5A5A5A5, 0, "alias_retire");
    addVec(1, 1, 32'hFFFFFFFF, 32'h10, 32'h0,        32'hA5A5A5A5, 0, "alias_array_rd");
    addVec(1, 0, 32'hFFFFFF00, 32'h10, 32'hxxxxxx3C, 32'hA5A5A5A5, 1, "xdata_wr");
    addVec(1, 1, 32'hFFFFFFFF, 32'h10, 32'h0,        32'hA5A5A53C, 1, "xdata_merge_rd");
    addVec(0, 0, 32'hFFFFFFFF, 32'h00, 32'h0,        32'hA5A5A53C, 0, "xdata_retire");
    addVec(1, 1, 32'hFFFFFFFF, 32'h10, 32'h0,        32'hA5A5A53C, 0, "xdata_array_rd");
    addVec(0, 1, 32'hFFFFFFFF, 32'h20, 32'h0,        32'hA5A5A53C, 0, "cen_low_rd");

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].c_en, vecs[k].r_en, vecs[k].w_en, vecs[k].addr, vecs[k].wdata);
      checkOutput({vecs[k].name, "_rd"}, DM_rd_data, vecs[k].exp_rd);
      checkOutput({vecs[k].name, "_wb"}, {31'h0, wb_valid}, {31'h0, vecs[k].exp_wb});
      checkOutput({vecs[k].name, "_ready"}, {31'h0, dm_ready}, 32'h1);
    end

    // Reset while the buffer is full discards the pending write.
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h3C, 32'h77777777);
    checkOutput("discard_wb_set", {31'h0, wb_valid}, 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("discard_wb_cleared", {31'h0, wb_valid}, 32'h0);
    checkOutput("discard_rd_cleared", DM_rd_data, 32'h0);
    checkOutput("discard_not_ready", {31'h0, dm_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    waitReady("init_r", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h3C, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h3C, 32'h0);
    checkOutput("post_discard_rd_3c", DM_rd_data, 32'h0);
    checkOutput("post_discard_wb", {31'h0, wb_valid}, 32'h0);
    idleCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
